ps2_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte, e.g. 0xED (set LEDs) or 0xF4 (enable), to the keyboard over the open-collector ps2_clk/ps2_data lines. It sits beside the PS/2 receiver, which ignores the bus while busy=1. The top level drives each pad low when its *_oe output is 1 and releases it (pull-up) when it is 0.

---
 rtl/ps2_tx.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, then clocks one command byte
// out under device clocking and checks the ack. Define PS2_TX_RETRY_EN to retry failed frames.
module ps2_tx #(
    parameter int INHIBIT_CYCLES    = 5000,
    parameter int START_HOLD_CYCLES = 100,
    parameter int TIMEOUT_CYCLES    = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int MAX_CYC = max3(INHIBIT_CYCLES, START_HOLD_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

    localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(START_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             nack_q, nack_d;
    logic [2:0]       clk_sync_q, data_sync_q;
`ifdef PS2_TX_RETRY_EN
    logic [9:0]       frame_q, frame_d;
    logic [1:0]       retry_q, retry_d;
`endif

    logic       clk_s, data_s, clk_fall, timeout;
    logic       attempt_end, attempt_fail;
    logic [9:0] frame_in;

    // Stage [1] is the current synchronized level, stage [2] the previous one.
    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];
    assign timeout  = (cnt_q == TO_LAST);
    assign frame_in = {1'b1, ~^tx_data, tx_data};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        clk_oe_d     = clk_oe_q;
        data_oe_d    = data_oe_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        nack_d       = nack_q;
        attempt_end  = 1'b0;
        attempt_fail = 1'b0;
`ifdef PS2_TX_RETRY_EN
        frame_d      = frame_q;
        retry_d      = retry_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (tx_start) begin
                    state_d   = ST_INHIBIT;
                    shift_d   = frame_in;
                    busy_d    = 1'b1;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    cnt_d     = '0;
                    nack_d    = 1'b0;
`ifdef PS2_TX_RETRY_EN
                    frame_d   = frame_in;
                    retry_d   = 2'd0;
`endif
                end
            end

            ST_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_START;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_START: begin
                if (cnt_q == HOLD_LAST) begin
                    clk_oe_d  = 1'b0;
                    bit_cnt_d = 4'd0;
                    cnt_d     = '0;
                    state_d   = ST_SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // From clock release onward the shared counter is the timeout watchdog.
            ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout) begin
                    attempt_end  = 1'b1;
                    attempt_fail = 1'b1;
                end else if (state_q == ST_SEND) begin
                    if (clk_fall) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[9:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd9) begin
                            state_d = ST_ACK;
                        end
                    end
                end else if (state_q == ST_ACK) begin
                    if (clk_fall) begin
                        nack_d  = data_s;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    if (clk_s && data_s) begin
                        attempt_end  = 1'b1;
                        attempt_fail = nack_q;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (attempt_end) begin
`ifdef PS2_TX_RETRY_EN
            if (attempt_fail && (retry_q != 2'd2)) begin
                retry_d   = retry_q + 2'd1;
                shift_d   = frame_q;
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                cnt_d     = '0;
                nack_d    = 1'b0;
                state_d   = ST_INHIBIT;
            end else
`endif
            begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                err_d     = attempt_fail;
                state_d   = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 10'd0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            nack_q      <= 1'b0;
            clk_sync_q  <= 3'd0;
            data_sync_q <= 3'd0;
`ifdef PS2_TX_RETRY_EN
            frame_q     <= 10'd0;
            retry_q     <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            nack_q      <= nack_d;
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[1:0], ps2_data};
`ifdef PS2_TX_RETRY_EN
            frame_q     <= frame_d;
            retry_q     <= retry_d;
`endif
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 keyboard model clocks frames out of the host; a monitor
// scores every done pulse against expectations queued by the stimulus.
module tb_ps2_tx;

    localparam int INH  = 20;
    localparam int HOLD = 4;
    localparam int TO   = 2000;
    localparam int H    = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       clk_oe, data_oe, busy, done, err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_pad, ps2_data_pad;

    assign ps2_clk_pad  = ~(clk_oe | dev_clk_low);
    assign ps2_data_pad = ~(data_oe | dev_data_low);

    ps2_tx #(
        .INHIBIT_CYCLES(INH),
        .START_HOLD_CYCLES(HOLD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk_pad),
        .ps2_data(ps2_data_pad),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .ps2_clk_oe(clk_oe),
        .ps2_data_oe(data_oe),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic       chk_lat;
        logic [3:0] nframes;
        logic [9:0] frame;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rel_cyc = 0;
    int         dev_frames = 0;
    int         done_seen = 0;
    logic [9:0] dev_frame = 10'd0;
    logic       clk_oe_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic e, input logic lat, input int nf, input logic [9:0] fr);
        exp_t x;
        x.err     = e;
        x.chk_lat = lat;
        x.nframes = 4'(nf);
        x.frame   = fr;
        exp_q.push_back(x);
    endtask

    // Monitor: cycle count, clock-release timestamp and done scoring.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (clk_oe_prev && !clk_oe) rel_cyc = cyc;
            clk_oe_prev = clk_oe;
            if (rst && done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    check("err", 32'(err), 32'(e.err));
                    check("busy_at_done", 32'(busy), 0);
                    check("oe_at_done", {30'd0, clk_oe, data_oe}, 0);
                    check("frames", dev_frames, 32'(e.nframes));
                    if (e.nframes != 0) check("frame", 32'(dev_frame), 32'(e.frame));
                    if (e.chk_lat) check("timeout_latency", cyc - rel_cyc, TO);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'h00;
    endtask

    // Keyboard model. mode 0: ack, 1: no ack, 2: never clocks.
    task automatic dev_run(input int mode, input int abort_fall, output bit aborted);
        int n;
        logic [9:0] f;
        aborted = 1'b0;
        n = 0;
        f = 10'd0;
        while (!(ps2_clk_pad === 1'b1 && ps2_data_pad === 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL start_request actual=absent required=present");
            return;
        end
        if (mode == 2) return;
        for (int i = 1; i <= 11; i++) begin
            repeat (H) @(negedge clk);
            if (i == 11 && mode == 0) begin
                dev_data_low = 1'b1;
                repeat (H / 2) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            if (i == abort_fall) begin
                aborted = 1'b1;
                return;
            end
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i <= 10) f[i-1] = ps2_data_pad;
            if (i == 10) begin
                dev_frame = f;
                dev_frames++;
            end
        end
        repeat (H) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input int tgt, input int budget);
        int n;
        n = 0;
        while (done_seen < tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_seen < tgt) begin
            checks++;
            errors++;
            $display("FAIL done_wait actual=none required=done");
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int tgt;
        int n_inh;
        int n_hold;
        bit ab;

        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(clk_oe), 0);
        check("rst_data_oe", 32'(data_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED: LSB first 1,0,1,1,0,1,1,1, parity 1, stop 1
        tgt = done_seen + 1;
        dev_frames = 0;
        push_exp(1'b0, 1'b0, 1, 10'b1_1_11101101);
        start_tx(8'hED);
        check("busy_after_start", 32'(busy), 1);
        n_inh = 0;
        while (clk_oe && !data_oe && n_inh < 100) begin
            n_inh++;
            @(negedge clk);
        end
        n_hold = 0;
        while (clk_oe && data_oe && n_hold < 100) begin
            n_hold++;
            @(negedge clk);
        end
        check("inhibit_cycles", n_inh, INH);
        check("start_hold_cycles", n_hold, HOLD);
        dev_run(0, 0, ab);
        wait_done(tgt, 2000);

        // 0xF4: 0,0,1,0,1,1,1,1, parity 0
        tgt = done_seen + 1;
        dev_frames = 0;
        push_exp(1'b0, 1'b0, 1, 10'b1_0_11110100);
        start_tx(8'hF4);
        dev_run(0, 0, ab);
        wait_done(tgt, 2000);

        // 0x55 without ack: parity 1
        tgt = done_seen + 1;
        dev_frames = 0;
`ifdef PS2_TX_RETRY_EN
        push_exp(1'b1, 1'b0, 3, 10'b1_1_01010101);
        start_tx(8'h55);
        for (int k = 0; k < 3; k++) dev_run(1, 0, ab);
`else
        push_exp(1'b1, 1'b0, 1, 10'b1_1_01010101);
        start_tx(8'h55);
        dev_run(1, 0, ab);
`endif
        wait_done(tgt, 2000);

        // Device never clocks: timeout 2000 cycles after clock release
        tgt = done_seen + 1;
        dev_frames = 0;
        push_exp(1'b1, 1'b1, 0, 10'd0);
        start_tx(8'hF4);
        wait_done(tgt, 8000);

        // Second start while busy is dropped
        tgt = done_seen + 1;
        dev_frames = 0;
        push_exp(1'b0, 1'b0, 1, 10'b1_0_11110100);
        start_tx(8'hF4);
        repeat (5) @(negedge clk);
        start_tx(8'hAA);
        dev_run(0, 0, ab);
        wait_done(tgt, 2000);

        // Asynchronous reset with the device holding fall 5
        dev_frames = 0;
        start_tx(8'h12);
        dev_run(0, 5, ab);
        check("abort_reached", 32'(ab), 1);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_clk_oe", 32'(clk_oe), 0);
        check("midrst_data_oe", 32'(data_oe), 0);
        check("midrst_busy", 32'(busy), 0);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

`ifdef PS2_TX_RETRY_EN
        // Two failed attempts then an ack
        tgt = done_seen + 1;
        dev_frames = 0;
        push_exp(1'b0, 1'b0, 3, 10'b1_1_11101101);
        start_tx(8'hED);
        dev_run(1, 0, ab);
        dev_run(1, 0, ab);
        dev_run(0, 0, ab);
        wait_done(tgt, 2000);
`endif

        check("exp_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
